// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: run control, opcode, memory handshake and datapath strobes between sequencer and core
interface multicycle_sequencer_if #(
  parameter int INSTRET_W = 32
);
  logic                 en;
  logic [6:0]           opcode;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 pc_write;
  logic                 alu_src;
  logic                 mem_to_reg;
  logic                 reg_write;
  logic [2:0]           state;
  logic                 mem_err;
  logic                 illegal;
  logic [INSTRET_W-1:0] instret;
  modport master (
    input  en, opcode, mem_ready,
    output mem_req, mem_read, mem_write, ir_write, pc_write, alu_src,
           mem_to_reg, reg_write, state, mem_err, illegal, instret
  );
  modport slave (
    output en, opcode, mem_ready,
    input  mem_req, mem_read, mem_write, ir_write, pc_write, alu_src,
           mem_to_reg, reg_write, state, mem_err, illegal, instret
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/execute/mem/writeback control FSM with memory timeout and retire counter; ILLEGAL_TRAP_EN enables illegal-opcode trapping
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_sequencer_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, ERROR, TRAP} state_t;
  typedef enum logic [1:0] {C_OP, C_OP_IMM, C_LOAD, C_STORE} cls_t;
  state_t               state_q;
  cls_t                 cls_q, cls_d;
  logic                 legal_d, expired_d, mem_err_q, illegal_q;
  logic [CW-1:0]        wait_q;
  logic [INSTRET_W-1:0] instret_q;
  // classify the opcode presented during DECODE
  always_comb begin
    cls_d   = C_OP;
    legal_d = 1'b1;
    case (bus.opcode)
      7'b0110011: cls_d = C_OP;
      7'b0010011: cls_d = C_OP_IMM;
      7'b0000011: cls_d = C_LOAD;
      7'b0100011: cls_d = C_STORE;
      default:    legal_d = 1'b0;
    endcase
  end
  assign expired_d = !bus.mem_ready && (int'(wait_q) + 1 >= MEM_TIMEOUT);
  // state, opcode class, wait counter, sticky flags and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cls_q     <= C_OP;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.en) state_q <= FETCH;
        FETCH, MEM:
          if (bus.mem_ready) begin
            wait_q <= '0;
            if (state_q == FETCH) state_q <= DECODE;
            else if (cls_q == C_LOAD) state_q <= WB;
            else begin
              state_q   <= FETCH;
              instret_q <= instret_q + 1'b1;
            end
          end else if (expired_d) begin
            state_q   <= ERROR;
            mem_err_q <= 1'b1;
          end else wait_q <= wait_q + 1'b1;
        DECODE:
          if (legal_d) begin
            state_q <= EXECUTE;
            cls_q   <= cls_d;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_q   <= TRAP;
            illegal_q <= 1'b1;
`else
            state_q <= FETCH;
`endif
          end
        EXECUTE: state_q <= (cls_q == C_LOAD || cls_q == C_STORE) ? MEM : WB;
        WB: begin
          state_q   <= FETCH;
          instret_q <= instret_q + 1'b1;
        end
        default: state_q <= state_q;
      endcase
    end
  end
  assign bus.state      = state_q;
  assign bus.mem_req    = state_q == FETCH || state_q == MEM;
  assign bus.mem_read   = state_q == FETCH || (state_q == MEM && cls_q == C_LOAD);
  assign bus.mem_write  = state_q == MEM && cls_q == C_STORE;
  assign bus.ir_write   = state_q == FETCH && bus.mem_ready;
  assign bus.pc_write   = state_q == FETCH && bus.mem_ready;
  assign bus.alu_src    = (state_q == EXECUTE || state_q == MEM || state_q == WB) && cls_q != C_OP;
  assign bus.mem_to_reg = state_q == WB && cls_q == C_LOAD;
  assign bus.reg_write  = state_q == WB;
  assign bus.mem_err    = mem_err_q;
  assign bus.illegal    = illegal_q;
  assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction streams checked cycle by cycle against a per-instruction trace model
module tb_multicycle_sequencer;
  localparam int TMO = 16;
  localparam int IW  = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_ERR = 3'd6, S_TRAP = 3'd7;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_OP = 7'b0110011, OP_IMM = 7'b0010011;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  multicycle_sequencer_if #(.INSTRET_W(IW)) bus ();
  multicycle_sequencer #(.MEM_TIMEOUT(TMO), .INSTRET_W(IW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [2:0]    st;
    logic          rdy;
    logic          en;
    logic [6:0]    op;
    logic [7:0]    strb;
    logic          err;
    logic          ill;
    logic [IW-1:0] ret;
  } cyc_t;
  cyc_t q[$];
  int nchk = 0;
  int nerr = 0;
  logic [IW-1:0] m_ret;
  logic m_err, m_ill;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit legal(logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_OP || op == OP_IMM;
  endfunction
  // strobe vector {mem_req,mem_read,mem_write,ir_write,pc_write,alu_src,mem_to_reg,reg_write} a phase must show
  function automatic logic [7:0] strobes(logic [2:0] st, logic [6:0] op, logic rdy);
    logic ld, sd, imm, ewm;
    ld  = op == OP_LOAD;
    sd  = op == OP_STORE;
    imm = ld || sd || op == OP_IMM;
    ewm = st == S_EXEC || st == S_MEM || st == S_WB;
    return {st == S_FETCH || st == S_MEM, st == S_FETCH || (st == S_MEM && ld), st == S_MEM && sd,
            st == S_FETCH && rdy, st == S_FETCH && rdy, ewm && imm, st == S_WB && ld, st == S_WB};
  endfunction
  function automatic logic [7:0] dut_strobes();
    return {bus.mem_req, bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write,
            bus.alu_src, bus.mem_to_reg, bus.reg_write};
  endfunction
  task automatic push(logic [2:0] st, logic rdy, logic [6:0] op, logic en);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.en = en; c.op = op;
    c.strb = strobes(st, op, rdy);
    c.err = m_err; c.ill = m_ill; c.ret = m_ret;
    q.push_back(c);
  endtask
  task automatic push_rnd(logic [2:0] st, logic rdy);
    push(st, rdy, 7'($urandom), 1'($urandom));
  endtask
  task automatic add_start(int n);
    repeat (n) push(S_IDLE, 1'($urandom), 7'($urandom), 1'b0);
    push(S_IDLE, 1'($urandom), 7'($urandom), 1'b1);
  endtask
  task automatic add_fetch(int wf);
    repeat (wf) push_rnd(S_FETCH, 1'b0);
    push_rnd(S_FETCH, 1'b1);
  endtask
  task automatic add_tail(logic [2:0] st, int n);
    repeat (n) push_rnd(st, 1'($urandom));
  endtask
  // one instruction: fetch with wf stalls, decode, then class-dependent execute/memory/writeback
  task automatic add_instr(logic [6:0] op, int wf, int wm, output bit halted);
    halted = 1'b0;
    add_fetch(wf);
    push(S_DECODE, 1'($urandom), op, 1'($urandom));
    if (!legal(op)) begin
`ifdef ILLEGAL_TRAP_EN
      m_ill = 1'b1;
      halted = 1'b1;
`endif
      return;
    end
    push(S_EXEC, 1'($urandom), op, 1'($urandom));
    if (op == OP_LOAD || op == OP_STORE) begin
      repeat (wm) push(S_MEM, 1'b0, op, 1'($urandom));
      push(S_MEM, 1'b1, op, 1'($urandom));
      if (op == OP_STORE) begin
        m_ret = m_ret + 1'b1;
        return;
      end
    end
    push(S_WB, 1'($urandom), op, 1'($urandom));
    m_ret = m_ret + 1'b1;
  endtask
  task automatic add_fetch_timeout();
    repeat (TMO) push_rnd(S_FETCH, 1'b0);
    m_err = 1'b1;
    add_tail(S_ERR, 3);
  endtask
  task automatic add_mem_timeout(int wf);
    logic [6:0] op;
    op = $urandom_range(0, 1) ? OP_LOAD : OP_STORE;
    add_fetch(wf);
    push(S_DECODE, 1'($urandom), op, 1'($urandom));
    push(S_EXEC, 1'($urandom), op, 1'($urandom));
    repeat (TMO) push(S_MEM, 1'b0, op, 1'($urandom));
    m_err = 1'b1;
    add_tail(S_ERR, 3);
  endtask
  function automatic int rand_wait();
    return ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 3));
  endfunction
  function automatic logic [6:0] rand_op();
    logic [6:0] o;
    if ($urandom_range(0, 9) < 2) begin
      do o = 7'($urandom); while (legal(o));
    end else begin
      case ($urandom_range(0, 3))
        0: o = OP_LOAD;
        1: o = OP_STORE;
        2: o = OP_OP;
        default: o = OP_IMM;
      endcase
    end
    return o;
  endfunction
  function automatic int count_st(logic [2:0] st);
    int n = 0;
    foreach (q[i]) if (q[i].st == st) n++;
    return n;
  endfunction
  function automatic int count_bit(int b);
    int n = 0;
    foreach (q[i]) if (q[i].strb[b]) n++;
    return n;
  endfunction
  function automatic logic [14:0] trace5();
    logic [14:0] t = '0;
    for (int i = 1; i <= 5; i++) t = {t[11:0], q[i].st};
    return t;
  endfunction
  task automatic do_reset();
    bus.en = 1'b0;
    rst_n = 1'b0;
    m_ret = '0; m_err = 1'b0; m_ill = 1'b0;
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  // drive each planned cycle on the falling edge and compare the DUT just after
  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      bus.en = c.en; bus.mem_ready = c.rdy; bus.opcode = c.op;
      #1;
      chk("state", 32'(bus.state), 32'(c.st));
      chk("strobes", 32'(dut_strobes()), 32'(c.strb));
      chk("mem_err", 32'(bus.mem_err), 32'(c.err));
      chk("illegal", 32'(bus.illegal), 32'(c.ill));
      chk("instret", 32'(bus.instret), 32'(c.ret));
    end
  endtask
  initial begin
    bit h;
    bus.en = 1'b0; bus.mem_ready = 1'b0; bus.opcode = '0;
    do_reset();
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_strobes", 32'(dut_strobes()), 32'd0);
    chk("reset_instret", 32'(bus.instret), 32'd0);
    add_start(0);
    add_instr(OP_OP, 0, 0, h);
    push_rnd(S_FETCH, 1'b0);
    chk("model_op_trace", 32'(trace5()), 32'(15'b001_010_011_101_001));
    run();
    chk("op_instret", 32'(bus.instret), 32'd1);
    do_reset();
    add_start(1);
    add_instr(OP_LOAD, 0, 3, h);
    push_rnd(S_FETCH, 1'b0);
    chk("model_load_mem_cycles", 32'(count_st(S_MEM)), 32'd4);
    chk("model_load_mem_to_reg", 32'(count_bit(1)), 32'd1);
    run();
    chk("load_instret", 32'(bus.instret), 32'd1);
    do_reset();
    add_start(0);
    add_instr(OP_STORE, 0, 0, h);
    push_rnd(S_FETCH, 1'b0);
    chk("model_store_mem_write", 32'(count_bit(5)), 32'd1);
    chk("model_store_reg_write", 32'(count_bit(0)), 32'd0);
    run();
    chk("store_state", 32'(bus.state), 32'd1);
    chk("store_instret", 32'(bus.instret), 32'd1);
    do_reset();
    add_start(0);
    add_fetch_timeout();
    chk("model_timeout_fetch_cycles", 32'(count_st(S_FETCH)), 32'd16);
    run();
    chk("timeout_state", 32'(bus.state), 32'd6);
    chk("timeout_mem_err", 32'(bus.mem_err), 32'd1);
    chk("timeout_mem_req", 32'(bus.mem_req), 32'd0);
    do_reset();
    add_start(0);
    add_instr(7'b1111111, 0, 0, h);
    if (h) add_tail(S_TRAP, 3);
    else push_rnd(S_FETCH, 1'b0);
    run();
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_state", 32'(bus.state), 32'd7);
    chk("illegal_flag", 32'(bus.illegal), 32'd1);
`else
    chk("illegal_state", 32'(bus.state), 32'd1);
    chk("illegal_flag", 32'(bus.illegal), 32'd0);
`endif
    chk("illegal_instret", 32'(bus.instret), 32'd0);
    do_reset();
    add_start(0);
    add_instr(OP_IMM, 0, 0, h);
    add_instr(OP_OP, 1, 0, h);
    push_rnd(S_FETCH, 1'b0);
    push_rnd(S_FETCH, 1'b0);
    run();
    chk("pre_reset_instret", 32'(bus.instret), 32'd2);
    chk("pre_reset_mem_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 32'(bus.state), 32'd0);
    chk("async_reset_strobes", 32'(dut_strobes()), 32'd0);
    chk("async_reset_instret", 32'(bus.instret), 32'd0);
    for (int s = 0; s < 40; s++) begin
      int k;
      h = 1'b0;
      k = $urandom_range(1, 24);
      do_reset();
      add_start($urandom_range(0, 3));
      for (int i = 0; i < k && !h; i++) add_instr(rand_op(), rand_wait(), rand_wait(), h);
      if (h) add_tail(S_TRAP, 3);
      else begin
        case ($urandom_range(0, 2))
          0: add_fetch_timeout();
          1: add_mem_timeout(rand_wait());
          default: push_rnd(S_FETCH, 1'b0);
        endcase
      end
      run();
    end
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
